// File: rtl/palette_ram_ctrl.sv
// 32 x 6-bit palette store: ROM copy after reset or init_start, then pixel/CPU arbitration; one-cycle read/ack latency.
// Pixel reads win unless a CPU request has waited MAX_WAIT cycles; PALETTE_MIRROR_EN enables the 0x1x->0x0x sprite aliasing.
module palette_ram_ctrl #(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_start,
  output logic       init_busy,
  output logic [4:0] rom_addr,
  input  logic [7:0] rom_dout,
  input  logic       pix_req,
  input  logic [4:0] pix_idx,
  output logic       pix_valid,
  output logic [5:0] pix_color,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [4:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [5:0]        mem_q [32];
  logic [5:0]        mem_d [32];
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pix_valid_q, pix_valid_d;
  logic [5:0]        pix_color_q, pix_color_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;

  logic run;
  logic cpu_grant;
  logic pix_grant;
  logic unused_bits;

  function automatic logic [4:0] map_addr(input logic [4:0] a);
`ifdef PALETTE_MIRROR_EN
    map_addr = (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
`else
    map_addr = a;
`endif
  endfunction

  assign run       = (state_q == S_RUN);
  // The ack cycle blocks a second grant to a request that is still held high.
  assign cpu_grant = run & ~init_start & cpu_req & ~cpu_ack_q & (~pix_req | (wait_q == WAIT_MAX));
  assign pix_grant = run & ~init_start & pix_req & ~cpu_grant;

  assign init_busy   = (state_q == S_INIT);
  assign rom_addr    = (state_q == S_INIT) ? cnt_q : 5'd0;
  assign pix_valid   = pix_valid_q;
  assign pix_color   = pix_color_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign unused_bits = ^{rom_dout[7:6], cpu_wdata[7:6]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_d       = mem_q;
    wait_d      = wait_q;
    pix_valid_d = 1'b0;
    pix_color_d = pix_color_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;

    case (state_q)
      S_INIT: begin
        mem_d[map_addr(cnt_q)] = rom_dout[5:0];
        cnt_d = cnt_q + 5'd1;
        if (init_start) begin
          cnt_d = 5'd0;
        end else if (cnt_q == 5'd31) begin
          state_d = S_RUN;
        end
      end
      default: begin
        if (init_start) begin
          state_d = S_INIT;
          cnt_d   = 5'd0;
        end
      end
    endcase

    if (pix_grant) begin
      pix_valid_d = 1'b1;
      pix_color_d = mem_q[map_addr(pix_idx)];
    end

    if (cpu_grant) begin
      cpu_ack_d = 1'b1;
      if (cpu_we) begin
        mem_d[map_addr(cpu_addr)] = cpu_wdata[5:0];
        cpu_rdata_d = {2'b00, cpu_wdata[5:0]};
      end else begin
        cpu_rdata_d = {2'b00, mem_q[map_addr(cpu_addr)]};
      end
    end

    if (!cpu_req || cpu_grant) begin
      wait_d = '0;
    end else if (run && !cpu_ack_q && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
      wait_q      <= '0;
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
      wait_q      <= wait_d;
      pix_valid_q <= pix_valid_d;
      pix_color_q <= pix_color_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_palette_ram_ctrl.sv
// Scoreboarded bench for palette_ram_ctrl; expectations come from a ROM table and a palette model.
module tb_palette_ram_ctrl;

  localparam int MAX_WAIT = 8;

  logic       clk;
  logic       rst_n;
  logic       init_start;
  logic       init_busy;
  logic [4:0] rom_addr;
  logic [7:0] rom_dout;
  logic       pix_req;
  logic [4:0] pix_idx;
  logic       pix_valid;
  logic [5:0] pix_color;
  logic       cpu_req;
  logic       cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;

  logic [7:0] rom_tbl [32];
  logic [5:0] exp_mem [32];
  logic [5:0] pix_exp_q [$];
  logic [7:0] cpu_exp_q [$];
  logic       hold_mode;
  logic [5:0] hold_exp;

  int n_vec;
  int n_bad;

  palette_ram_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_busy(init_busy),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .pix_req(pix_req), .pix_idx(pix_idx), .pix_valid(pix_valid), .pix_color(pix_color),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata)
  );

  assign rom_dout = rom_tbl[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] pmap(input logic [4:0] a);
`ifdef PALETTE_MIRROR_EN
    pmap = (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
`else
    pmap = a;
`endif
  endfunction

  task automatic reload_model();
    for (int i = 0; i < 32; i++) exp_mem[pmap(5'(i))] = rom_tbl[i][5:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int busy);
    busy = 0;
    for (int i = 0; i < 40 && init_busy; i++) begin
      busy++;
      tick();
    end
  endtask

  task automatic pix_read(input logic [4:0] idx);
    pix_req = 1'b1;
    pix_idx = idx;
    pix_exp_q.push_back(exp_mem[pmap(idx)]);
    tick();
    pix_req = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic [4:0] a, input logic [7:0] d);
    logic got;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    if (we) begin
      exp_mem[pmap(a)] = d[5:0];
      cpu_exp_q.push_back({2'b00, d[5:0]});
    end else begin
      cpu_exp_q.push_back({2'b00, exp_mem[pmap(a)]});
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (cpu_ack) got = 1'b1;
    end
    chk("cpu_ack_seen", cpu_ack, 1);
    cpu_req = 1'b0;
  endtask

  // Output monitor: every pixel/CPU result is matched against the queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid) begin
        if (hold_mode) chk("pix_hold_color", pix_color, hold_exp);
        else if (pix_exp_q.size() == 0) chk("pix_unexpected", pix_valid, 0);
        else chk("pix_color", pix_color, pix_exp_q.pop_front());
      end
      if (cpu_ack) begin
        if (cpu_exp_q.size() == 0) chk("cpu_unexpected", cpu_ack, 0);
        else chk("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int zeros;
    int ack_cyc;
    int ack_in_busy;

    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; init_start = 1'b0;
    pix_req = 1'b0; pix_idx = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    hold_mode = 1'b0; hold_exp = '0;
    for (int i = 0; i < 32; i++) rom_tbl[i] = 8'(i * 37 + 8'h81);
    rom_tbl[5'h00] = 8'h0F;
    rom_tbl[5'h01] = 8'h15;
    rom_tbl[5'h05] = 8'hE7;
    rom_tbl[5'h0A] = 8'h36;
    rom_tbl[5'h10] = 8'h8D;
    rom_tbl[5'h1E] = 8'h67;

    #3;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_init_busy", init_busy, 1);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_color", pix_color, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    reload_model();
    wait_init(busy);
    chk("init_cycles", busy, 32);
    chk("init_busy_run", init_busy, 0);

    pix_read(5'h05);
    pix_read(5'h0A);
    pix_read(5'h1E);
    tick();

    cpu_op(1'b1, 5'h03, 8'hFF);
    cpu_op(1'b0, 5'h03, 8'h00);
    pix_read(5'h03);
    tick();

    // Continuous pixel traffic against a pending CPU write.
    pix_idx = 5'h07; pix_req = 1'b1;
    hold_exp = exp_mem[pmap(5'h07)]; hold_mode = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h02; cpu_wdata = 8'hEA;
    exp_mem[pmap(5'h02)] = 6'h2A;
    cpu_exp_q.push_back(8'h2A);
    zeros = 0; ack_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (!pix_valid) zeros++;
      if (cpu_ack && ack_cyc < 0) ack_cyc = c;
    end
    chk("wait_ack_pulse", cpu_ack, 0);
    cpu_req = 1'b0; pix_req = 1'b0;
    chk("wait_ack_cycles", ack_cyc + 1, MAX_WAIT + 2);
    chk("wait_pix_gaps", zeros, 1);
    tick(); tick();
    hold_mode = 1'b0;
    pix_read(5'h02);
    tick();

    cpu_op(1'b1, 5'h10, 8'h21);
    cpu_op(1'b0, 5'h00, 8'h00);
    cpu_op(1'b0, 5'h10, 8'h00);
    pix_read(5'h00);
    tick();

    // Reload from ROM with a CPU read held across the copy.
    cpu_op(1'b1, 5'h05, 8'h00);
    pix_read(5'h05);
    tick();
    chk("pre_init_busy", init_busy, 0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h05; init_start = 1'b1;
    tick();
    init_start = 1'b0;
    reload_model();
    cpu_exp_q.push_back({2'b00, exp_mem[pmap(5'h05)]});
    busy = 0; ack_in_busy = 0; ack_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (init_busy) busy++;
      if (cpu_ack) begin
        if (init_busy) ack_in_busy++;
        if (ack_cyc < 0) ack_cyc = c;
        cpu_req = 1'b0;
      end
      tick();
    end
    chk("reinit_cycles", busy, 32);
    chk("reinit_ack_blocked", ack_in_busy, 0);
    chk("reinit_ack_cycle", ack_cyc, 34);
    pix_read(5'h0A);
    tick();

    // Asynchronous reset in the middle of a copy.
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("mid_init_rom_addr", rom_addr, 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_init_busy", init_busy, 1);
    chk("arst_pix_valid", pix_valid, 0);
    chk("arst_pix_color", pix_color, 0);
    chk("arst_cpu_ack", cpu_ack, 0);
    chk("arst_cpu_rdata", cpu_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    reload_model();
    wait_init(busy);
    chk("post_rst_init_cycles", busy, 32);
    pix_read(5'h01);
    tick(); tick();

    chk("pix_queue_left", pix_exp_q.size(), 0);
    chk("cpu_queue_left", cpu_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/palette_ram_ctrl.md
Name: palette_ram_ctrl

Overview:
Owns the 32-entry NES palette store (32 x 6-bit colour indices) and schedules all access to it.
- After reset it copies the 32 bytes of the combinational palette ROM into internal registers.
- It then arbitrates single-port access between the pixel renderer (reads) and the CPU/PPU-register side (reads and writes).
- Sits between the palette ROM and the PPU pixel output stage.

Parameters:
MAX_WAIT, 8, cycles a CPU request may be blocked by pixel reads before it is forced through (1..15)
WAIT_W, 4, width of the CPU wait counter

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
init_start  in  1  one-cycle pulse: reload the palette from ROM
init_busy  out  1  high while the ROM copy runs
rom_addr  out  5  address to the palette ROM
rom_dout  in  8  palette ROM data, valid in the same cycle as rom_addr
pix_req  in  1  renderer read request
pix_idx  in  5  palette entry to read
pix_valid  out  1  pix_color holds the data for the previous cycle's pix_req
pix_color  out  6  colour index read
cpu_req  in  1  CPU request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  in  5  palette entry
cpu_wdata  in  8  write data; bits 7:6 are ignored
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  {2'b00, entry}, valid while cpu_ack is high

Behaviour:
- Reset (async, rst_n low):
  - Storage is cleared to 0; state is INIT; the copy counter is 0.
  - rom_addr=0, init_busy=1, pix_valid=0, pix_color=0, cpu_ack=0, cpu_rdata=0, wait counter=0.
- States: INIT, RUN.
- INIT:
  - rom_addr = counter. At each edge, entry[map(counter)] <= rom_dout[5:0] and the counter increments.
  - After the write of entry 31, the next state is RUN; init_busy drops in the first RUN cycle. INIT lasts exactly 32 cycles.
  - No grants during INIT: pix_valid=0, cpu_ack=0. A pending cpu_req stays pending and is served in RUN.
  - init_start during INIT restarts the counter at 0.
- RUN:
  - init_start moves to INIT with counter 0 on the next edge. A cpu_req in the same cycle is not granted.
  - rom_addr holds 0 in RUN.
- Arbitration in RUN: exactly one storage access per cycle. The grant is combinational and registered at the edge.
  - cpu_ack high blocks a CPU grant that cycle, so a held request is not double-served.
  - cpu_grant = cpu_req & ~cpu_ack & (~pix_req | wait==MAX_WAIT). Otherwise pix_req wins.
- Pixel read granted in cycle N: at cycle N+1, pix_valid=1 and pix_color=entry[map(pix_idx)].
  - If pix_req is not granted or absent, pix_valid=0 at N+1 and pix_color holds its old value.
- CPU access granted in cycle N:
  - Write: entry[map(cpu_addr)] <= cpu_wdata[5:0] at the edge.
  - Read: cpu_rdata <= {2'b00, entry}.
  - At N+1, cpu_ack=1 for one cycle. For a write, cpu_rdata = {2'b00, cpu_wdata[5:0]}.
  - A pixel read in the cycle after the write sees the new value.
- Wait counter:
  - Increments, saturating at MAX_WAIT, in each RUN cycle with cpu_req & ~cpu_ack & not granted.
  - Clears on CPU grant or when cpu_req is low.
- The ROM value's upper bits 7:6 are dropped.

Optional Feature:
PALETTE_MIRROR_EN:
- Defined: map(a) = (a[4] & a[1:0]==0) ? {1'b0, a[3:0]} : a. Addresses 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C on read and write, including ROM copy; the last write wins. Entries 0x10/0x14/0x18/0x1C are never written.
- Undefined: map(a) = a; all 32 entries are independent.

Test Plan:
- Reset release, wait 32 cycles, then pix_req with pix_idx=0x05 -> init_busy low; next cycle pix_valid=1, pix_color=0x27. pix_idx=0x0A -> 0x36; pix_idx=0x1E -> 0x27.
- CPU write addr 0x03 data 0xFF, then CPU read addr 0x03 -> write ack has cpu_rdata=0x3F; read ack has cpu_rdata=0x3F. Following pix_idx=0x03 -> 0x3F.
- pix_req held high continuously and cpu_req write pending -> cpu_ack after exactly MAX_WAIT+2 cycles (10 at default). Exactly one cycle has pix_valid=0. cpu_ack is a single pulse while cpu_req is still high.
- CPU write 0x10 <- 0x21, then read 0x00 -> 0x21 with PALETTE_MIRROR_EN; 0x0F without it (0x10 reads 0x21).
- Overwrite entry 0x05 with 0x00, pulse init_start, hold cpu_req read of 0x05 -> init_busy high for 32 cycles, no ack meanwhile. Then ack with cpu_rdata=0x27.
- rst_n low during INIT at counter 10 -> all outputs at reset values immediately. After release, a full 32-cycle copy; entry 0x01=0x15.
